// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and
// the packed layout of one scoreboard entry ({rd, mem_read, reg_write, valid}).
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int SB_VALID  = 0;
  localparam int SB_RW     = 1;
  localparam int SB_MR     = 2;
  localparam int SB_FLAG_W = 3;

  // rd occupies the bits above the flags
  function automatic int sb_w(input int ra_w);
    return ra_w + SB_FLAG_W;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                       r_cnt <= '0;
    else if (clr)                   r_cnt <= '0;
    else if (inc && (r_cnt != '1))  r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage core: shadow scoreboard of EX/MEM/WB,
// hold/flush enables, EX forwarding selects and stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  input  logic                  clr_cnt,
  output logic                  pc_write_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int SB_W = sb_w(REG_ADDR_W);

  typedef logic [SB_W-1:0]       entry_t;
  typedef logic [REG_ADDR_W-1:0] ra_t;

  // x0 is hardwired zero, so it never creates a dependency
  function automatic logic hit(input logic used, input ra_t src, input entry_t e);
    return used && (src != '0) && e[SB_VALID] && e[SB_RW] &&
           (e[SB_W-1:SB_FLAG_W] == src);
  endfunction

  // Youngest producer (MEM) wins; loads in MEM are covered by the load-use stall
  function automatic logic [1:0] fwd_sel(input logic used, input ra_t src,
                                         input entry_t mem, input entry_t wb);
    if (hit(used, src, mem) && !mem[SB_MR]) return FWD_EXMEM;
    if (hit(used, src, wb))                 return FWD_MEMWB;
    return FWD_RF;
  endfunction

  entry_t r_ex, r_mem, r_wb;
  ra_t    r_ex_rs1, r_ex_rs2;
  logic   r_ex_use1, r_ex_use2;

  logic   w_ex_hit, w_mem_hit, w_stall, w_stall_eff, w_br, w_ex_load;
  entry_t w_id_entry;

  always_comb begin
    w_ex_hit  = id_valid && (hit(id_uses_rs1, id_rs1, r_ex) ||
                             hit(id_uses_rs2, id_rs2, r_ex));
    w_mem_hit = id_valid && (hit(id_uses_rs1, id_rs1, r_mem) ||
                             hit(id_uses_rs2, id_rs2, r_mem));
    if (FWD_EN != 0) begin
      w_stall = w_ex_hit && r_ex[SB_MR];
      fwd_a   = fwd_sel(r_ex_use1, r_ex_rs1, r_mem, r_wb);
      fwd_b   = fwd_sel(r_ex_use2, r_ex_rs2, r_mem, r_wb);
    end else begin
      w_stall = w_ex_hit || w_mem_hit;
      fwd_a   = FWD_RF;
      fwd_b   = FWD_RF;
    end
  end

  // A taken branch discards the stalled (wrong-path) instruction instead
  assign w_stall_eff  = w_stall & ~branch_taken;
  assign w_br         = branch_taken & enable;
  assign w_ex_load    = ~(w_stall_eff | branch_taken);
  assign w_id_entry   = {id_rd, id_mem_read, id_reg_write, id_valid};

  assign pc_write_en  = enable & ~w_stall_eff;
  assign if_id_en     = enable & ~w_stall_eff;
  assign id_ex_en     = enable;
  assign id_ex_flush  = enable & (w_stall_eff | branch_taken);
  assign if_id_flush  = w_br;
  assign ex_mem_flush = w_br;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
    end else if (enable) begin
      r_ex      <= w_ex_load ? w_id_entry : '0;
      r_ex_rs1  <= w_ex_load ? id_rs1 : '0;
      r_ex_rs2  <= w_ex_load ? id_rs2 : '0;
      r_ex_use1 <= w_ex_load & id_valid & id_uses_rs1;
      r_ex_use2 <= w_ex_load & id_valid & id_uses_rs2;
      r_mem     <= branch_taken ? '0 : r_ex;
      r_wb      <= r_mem;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .arst(arst),
    .inc (enable & w_stall_eff),
    .clr (clr_cnt),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .arst(arst),
    .inc (w_br),
    .clr (clr_cnt),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: a forwarding instance (u_dut) and a no-forwarding instance
// (u_dut0) share stimulus; each scenario checks against hand-derived values.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       arst, enable, id_valid, id_uses_rs1, id_uses_rs2;
  logic       id_reg_write, id_mem_read, branch_taken, clr_cnt;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       d1_pc, d1_ifid, d1_idex, d1_ifid_fl, d1_idex_fl, d1_exmem_fl;
  logic [1:0] d1_fa, d1_fb;
  logic [3:0] d1_scnt, d1_fcnt;
  logic       d0_pc, d0_ifid, d0_idex, d0_ifid_fl, d0_idex_fl, d0_exmem_fl;
  logic [1:0] d0_fa, d0_fb;
  logic [3:0] d0_scnt, d0_fcnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(4)) u_dut (
    .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken), .clr_cnt(clr_cnt),
    .pc_write_en(d1_pc), .if_id_en(d1_ifid), .id_ex_en(d1_idex),
    .if_id_flush(d1_ifid_fl), .id_ex_flush(d1_idex_fl), .ex_mem_flush(d1_exmem_fl),
    .fwd_a(d1_fa), .fwd_b(d1_fb), .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken), .clr_cnt(clr_cnt),
    .pc_write_en(d0_pc), .if_id_en(d0_ifid), .id_ex_en(d0_idex),
    .if_id_flush(d0_ifid_fl), .id_ex_flush(d0_idex_fl), .ex_mem_flush(d0_exmem_fl),
    .fwd_a(d0_fa), .fwd_b(d0_fb), .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // inputs change 2 time units after the edge, checks 1 unit later
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    step();
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1; enable = 1'b1; branch_taken = 1'b0; clr_cnt = 1'b0;
    idle();
    #1;
    chk("rst_pc",     d1_pc, 1);
    chk("rst_ifid",   d1_ifid, 1);
    chk("rst_idex",   d1_idex, 1);
    chk("rst_flush",  {d1_ifid_fl, d1_idex_fl, d1_exmem_fl}, 0);
    chk("rst_fwd",    {d1_fa, d1_fb}, 0);
    chk("rst_cnt",    {d1_scnt, d1_fcnt}, 0);
    step();
    arst = 1'b0;
    step();

    // load-use: lw x5 then consumer of x5
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    chk("lu_pc",      d1_pc, 0);
    chk("lu_ifid",    d1_ifid, 0);
    chk("lu_idexfl",  d1_idex_fl, 1);
    chk("lu_cnt0",    d1_scnt, 0);
    step();
    chk("lu_cnt1",    d1_scnt, 1);
    chk("lu_nostall", d1_pc, 1);
    step();
    idle();
    #1;
    chk("lu_fwd_a",   d1_fa, 2'b10);
    chk("lu_fwd_b",   d1_fb, 2'b00);
    drain();

    // ALU chain on x3
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    step();
    set_id(1, 3, 1, 3, 1, 4, 1, 0);
    #1;
    chk("alu_nostall", d1_pc, 1);
    step();
    set_id(1, 3, 1, 0, 1, 5, 1, 0);
    #1;
    chk("alu_fwd_ab", {d1_fa, d1_fb}, 4'b0101);
    step();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    #1;
    chk("alu_wb_a",   d1_fa, 2'b10);
    chk("alu_x0_b",   d1_fb, 2'b00);
    step();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    step();
    set_id(1, 3, 1, 3, 1, 8, 1, 0);
    step();
    idle();
    #1;
    chk("alu_mem_pri", {d1_fa, d1_fb}, 4'b0101);
    drain();

    // x0 as destination
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    step();
    set_id(1, 0, 1, 0, 0, 0, 1, 0);
    #1;
    chk("x0_nostall", d1_pc, 1);
    step();
    set_id(1, 0, 1, 0, 0, 9, 1, 0);
    step();
    idle();
    #1;
    chk("x0_fwd_a",   d1_fa, 2'b00);
    drain();

    // taken branch in the same cycle as a load-use stall
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    branch_taken = 1'b1;
    #1;
    chk("br_flushes", {d1_ifid_fl, d1_idex_fl, d1_exmem_fl}, 3'b111);
    chk("br_pc",      d1_pc, 1);
    chk("br_ifid",    d1_ifid, 1);
    step();
    branch_taken = 1'b0;
    idle();
    #1;
    chk("br_scnt",    d1_scnt, 1);
    chk("br_fcnt",    d1_fcnt, 1);

    // global enable low
    enable = 1'b0;
    branch_taken = 1'b1;
    set_id(1, 1, 1, 0, 0, 2, 1, 0);
    #1;
    chk("en0_enables", {d1_pc, d1_ifid, d1_idex}, 0);
    chk("en0_flushes", {d1_ifid_fl, d1_idex_fl, d1_exmem_fl}, 0);
    step();
    chk("en0_fcnt",   d1_fcnt, 1);
    enable = 1'b1;
    branch_taken = 1'b0;
    idle();

    // no-forwarding variant
    do_reset();
    chk("rst2_fcnt",  d1_fcnt, 0);
    set_id(1, 1, 1, 2, 1, 7, 1, 0);
    step();
    set_id(1, 1, 1, 0, 0, 10, 1, 0);
    step();
    set_id(1, 7, 1, 0, 0, 11, 1, 0);
    #1;
    chk("nf_mem_stall", d0_pc, 0);
    chk("fw_mem_nostall", d1_pc, 1);
    step();
    chk("nf_mem_done", d0_pc, 1);
    step();
    set_id(1, 1, 1, 2, 1, 7, 1, 0);
    #1;
    chk("nf_fwd",     {d0_fa, d0_fb}, 0);
    step();
    set_id(1, 7, 1, 0, 0, 11, 1, 0);
    #1;
    chk("nf_ex_stall1", d0_pc, 0);
    step();
    chk("nf_ex_stall2", d0_pc, 0);
    step();
    chk("nf_ex_done", d0_pc, 1);
    chk("nf_scnt",    d0_scnt, 3);
    idle();

    // saturation, reset mid-stall, clear
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      step();
      set_id(1, 5, 1, 0, 0, 6, 1, 0);
      step();
    end
    chk("sat_scnt",   d1_scnt, 15);
    chk("sat_scnt0",  d0_scnt, 15);
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    chk("mid_stall",  d1_pc, 0);
    arst = 1'b1;
    #1;
    chk("mid_rst_pc", d1_pc, 1);
    chk("mid_rst_fl", d1_idex_fl, 0);
    chk("mid_rst_cnt", d1_scnt, 0);
    step();
    arst = 1'b0;
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    step();
    chk("clr_pre",    d1_scnt, 1);
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    idle();
    chk("clr_pri",    d1_scnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control block for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of the instructions in EX, MEM and WB: destination register, reg_write, mem_read, valid.
- From the scoreboard it generates:
  - PC and IF/ID hold enables;
  - pipeline flushes for taken branches and jumps resolved in MEM;
  - EX-stage forwarding selects;
  - saturating stall and flush performance counters.
- Replaces the unconditional enable currently fed to every pipeline register.

Parameters:
REG_ADDR_W, 5, register-address width.
FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = no forwarding, stall on any RAW hazard against EX or MEM.
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  core clock.
arst  in  1  asynchronous reset, active-high.
enable  in  1  global run enable.
id_valid  in  1  ID stage holds a real instruction.
id_rs1  in  REG_ADDR_W  ID source register 1.
id_rs2  in  REG_ADDR_W  ID source register 2.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
id_rd  in  REG_ADDR_W  ID destination register.
id_reg_write  in  1  ID instruction writes rd.
id_mem_read  in  1  ID instruction is a load.
branch_taken  in  1  MEM stage redirects the PC (taken branch or jump).
clr_cnt  in  1  synchronous clear of both counters.
pc_write_en  out  1  PC update enable.
if_id_en  out  1  IF/ID register enable.
id_ex_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
if_id_flush  out  1  load NOP/invalid into IF/ID.
id_ex_flush  out  1  load bubble (all controls 0) into ID/EX.
ex_mem_flush  out  1  load bubble into EX/MEM.
fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback data.
fwd_b  out  2  EX operand B select, same encoding as fwd_a.
stall_cnt  out  CNT_W  cycles with hazard stall asserted.
flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:

Scoreboard entries (ex_*, mem_*, wb_*): valid, rd, reg_write, mem_read, plus ex_rs1/ex_rs2 with their use bits.
- Advance EX←ID, MEM←EX, WB←MEM when enable=1.
- A hazard stall loads a bubble (valid=0) into EX.
- branch_taken invalidates the EX entry and the ID→EX transfer; the MEM→WB transfer still occurs.

Hazard match:
- Condition: src used, src != 0, entry valid, entry reg_write, entry rd == src.
- Register x0 never matches.

Stall (combinational):
- FWD_EN=1: stall when id_valid and the ID instruction matches an EX entry that has mem_read=1 (load-use).
- FWD_EN=0: stall when id_valid and the ID instruction matches an EX or MEM entry.
- The register file is write-first, so a match against WB never stalls.

Output equations:
- Base terms: stall_eff = stall & ~branch_taken; br = branch_taken & enable.
- pc_write_en = enable & ~stall_eff.
- if_id_en = enable & ~stall_eff.
- id_ex_en = enable.
- id_ex_flush = enable & (stall_eff | branch_taken).
- if_id_flush = br.
- ex_mem_flush = br.
- A taken branch has priority over a stall: the stalled instruction is wrong-path and is discarded.

Forwarding:
- FWD_EN=0: fwd_a = fwd_b = 00.
- FWD_EN=1, per EX source:
  - 01 if it matches MEM and mem_mem_read=0;
  - else 10 if it matches WB;
  - else 00.
- MEM has priority over WB (youngest producer wins).
- A load in MEM never forwards; the load-use stall guarantees the load is in WB by the time its consumer reaches EX.

Counters:
- stall_cnt increments on enable & stall_eff.
- flush_cnt increments on br.
- Both saturate at all-ones; they never wrap.
- clr_cnt has priority over increment.

enable=0:
- All enables and flushes are 0.
- Scoreboard and counters hold.
- fwd_* still reflect the held state.

Reset (arst=1, asynchronous):
- All valid bits, rd fields and counters go to 0.
- Resulting outputs: fwd_*=00; flushes=0; pc_write_en = if_id_en = id_ex_en = enable.
- Reset mid-stall discards the stall immediately.

Latency:
- Stall and flush outputs respond combinationally in the same cycle.
- Scoreboard and counters update on the next rising clk edge.

Decomposition:
- Package hazard_pkg: localparams FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; the scoreboard entry field layout/width.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output cnt), instantiated twice.
- Stage registers use the existing reg_arstn_en-style enable registers, with polarity adapted to arst.

Test Plan:
- Load-use: EX=lw x5 (mem_read, rd=5), ID rs1=5, uses_rs1=1 → cycle 0: pc_write_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0→1; cycle 1: no stall; cycle 2: consumer in EX with fwd_a=10.
- ALU chain: add x3 then sub x4,x3,x3 back-to-back → no stall; fwd_a=fwd_b=01. With a third instruction reading x3: fwd=10 in the following cycle. Both MEM and WB writing x3 → 01 (MEM priority).
- x0 destination: EX=lw x0, ID rs1=0 → no stall, fwd_a=00.
- Branch vs stall: branch_taken=1 in the same cycle as a load-use stall → if_id_flush=ex_mem_flush=id_ex_flush=1, pc_write_en=1, stall_cnt unchanged, flush_cnt +1.
- FWD_EN=0: producer add x7 in MEM, ID reads x7 → stall for 1 cycle; producer in EX → stall 2 cycles; fwd always 00.
- Counter and reset: preload stall_cnt to all-ones via CNT_W=4 (15 stall cycles) → holds at 15; clr_cnt → 0. Assert arst mid-stall → stall deasserts asynchronously, counters read 0.
